// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared branch opcodes, ALU flag indices and redirect FSM states.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [4:0] c_OP_BEQ = 5'b10011;
    localparam logic [4:0] c_OP_BLT = 5'b10100;
    localparam logic [4:0] c_OP_BGT = 5'b10101;
    localparam logic [4:0] c_OP_BNE = 5'b10110;

    localparam int unsigned c_FLAG_EQ = 1;
    localparam int unsigned c_FLAG_LT = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2
    } br_state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones; clear wins over increment.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] c_MAX = '1;

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl
// Brief    : Resolves EX-stage branches, drives PC redirect/flush, squashes
//            wrong-path EX slots and keeps saturating branch statistics.
// Revision : 1.0
// ============================================================================
module branch_redirect_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [4:0]        ex_opcode,
    input  logic [1:0]        ex_flags,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              stall_in,
    input  logic              cnt_clr,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              busy,
    output logic [CNT_W-1:0]  br_total,
    output logic [CNT_W-1:0]  br_taken
);

    localparam int              c_SQ_W    = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES + 1) : 1;
    localparam logic [c_SQ_W-1:0] c_SQ_LOAD = c_SQ_W'(SQUASH_CYCLES);
    localparam logic [c_SQ_W-1:0] c_SQ_ONE  = c_SQ_W'(1);

    function automatic logic is_branch(input logic [4:0] op);
        return (op == c_OP_BEQ) || (op == c_OP_BLT) || (op == c_OP_BGT) || (op == c_OP_BNE);
    endfunction

    function automatic logic branch_taken(input logic [4:0] op, input logic [1:0] fl);
        logic t;
        t = 1'b0;
        case (op)
            c_OP_BEQ: t =  fl[c_FLAG_EQ];
            c_OP_BLT: t =  fl[c_FLAG_LT];
            c_OP_BGT: t = ~fl[c_FLAG_LT];
            c_OP_BNE: t = ~fl[c_FLAG_EQ];
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

    br_state_e         r_state;
    br_state_e         w_next_state;
    logic [c_SQ_W-1:0] r_sq_cnt;
    logic [c_SQ_W-1:0] w_next_sq_cnt;
    logic [ADDR_W-1:0] r_pc_target;
    logic              r_redirect;
    logic              r_busy;
    logic              w_resolve;
    logic              w_taken;

    // A branch held under stall resolves only on its first unstalled cycle.
    assign w_resolve = (r_state == ST_IDLE) && ex_valid && is_branch(ex_opcode) && !stall_in;
    assign w_taken   = w_resolve && branch_taken(ex_opcode, ex_flags);

    always_comb begin
        w_next_state  = r_state;
        w_next_sq_cnt = r_sq_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_taken) begin
                    w_next_state  = ST_REDIRECT;
                    w_next_sq_cnt = c_SQ_LOAD;
                end
            end
            ST_REDIRECT: begin
                if (!stall_in) begin
                    w_next_state = (SQUASH_CYCLES > 0) ? ST_SQUASH : ST_IDLE;
                end
            end
            ST_SQUASH: begin
                if (!stall_in) begin
                    w_next_sq_cnt = r_sq_cnt - c_SQ_ONE;
                    if (r_sq_cnt == c_SQ_ONE) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sq_cnt    <= '0;
            r_pc_target <= '0;
            r_redirect  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_sq_cnt   <= w_next_sq_cnt;
            r_redirect <= (w_next_state == ST_REDIRECT);
            r_busy     <= (w_next_state != ST_IDLE);
            if (w_taken) begin
                r_pc_target <= ex_target;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_total (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_resolve),
        .clr   (cnt_clr),
        .count (br_total)
    );

    sat_counter #(.W(CNT_W)) u_cnt_taken (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_taken),
        .clr   (cnt_clr),
        .count (br_taken)
    );

    assign pc_redirect = r_redirect;
    assign flush_if_id = r_redirect;
    assign flush_id_ex = r_redirect;
    assign pc_target   = r_pc_target;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Pipeline control block that resolves conditional branches in EX and sequences the resulting control-flow change. Each cycle it evaluates the EX-stage opcode against the ALU flags. On a taken branch it drives a PC redirect and flushes the IF/ID and ID/EX registers. It then squashes a fixed number of wrong-path EX slots and keeps saturating branch statistics. It sits between the ALU/EX stage and the fetch unit, and replaces the standalone registered branch-select decision.

## Interface
- ADDR_W, 16, width of PC / branch target
- SQUASH_CYCLES, 2, EX slots ignored after a redirect (0 allowed)
- CNT_W, 16, width of the statistics counters
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  EX stage holds a real instruction
- ex_opcode  in  5  EX-stage opcode
- ex_flags  in  2  ALU flags: [1]=zero (EQ), [0]=less-than (LT)
- ex_target  in  ADDR_W  computed branch target for the EX instruction
- stall_in  in  1  pipeline frozen this cycle (memory stall)
- cnt_clr  in  1  synchronous clear of statistics counters
- pc_redirect  out  1  fetch must load pc_target
- pc_target  out  ADDR_W  redirect address
- flush_if_id  out  1  clear IF/ID register
- flush_id_ex  out  1  clear ID/EX register
- busy  out  1  state ≠ IDLE
- br_total  out  CNT_W  branches resolved
- br_taken  out  CNT_W  branches taken

## Operation
- Branch opcodes and taken conditions:
  - BEQ 5'b10011: taken if flags[1]=1
  - BLT 5'b10100: taken if flags[0]=1
  - BGT 5'b10101: taken if flags[0]=0
  - BNE 5'b10110: taken if flags[1]=0
  - Any other opcode is not a branch.
- "Resolve" means state=IDLE & ex_valid & branch opcode & stall_in=0.
  - A branch held in EX across stall cycles resolves exactly once, on its first unstalled cycle.
- FSM states: IDLE, REDIRECT, SQUASH.
  - IDLE:
    - Resolve & taken → REDIRECT; latch ex_target into pc_target; load squash counter with SQUASH_CYCLES.
    - Resolve & not taken → stay in IDLE; count only.
  - REDIRECT:
    - pc_redirect, flush_if_id and flush_id_ex are all 1.
    - Stay while stall_in=1.
    - When stall_in=0 → SQUASH if SQUASH_CYCLES>0, else IDLE.
  - SQUASH:
    - ex_valid is ignored, so no resolves and no counting.
    - The counter decrements only on stall_in=0 cycles.
    - At the decrement from 1 → IDLE.
- Counters:
  - On each resolve, br_total increments; br_taken increments if the branch is taken.
  - Both saturate at all-ones and never wrap.
  - cnt_clr has priority over a same-cycle increment; the result is 0.
- pc_target holds its last latched value outside REDIRECT.

## Timing
- All outputs are registered.
- Reset: state=IDLE; pc_redirect, flush_if_id, flush_id_ex, busy = 0; pc_target=0; br_total=br_taken=0.
- Taken resolve in cycle N:
  - pc_redirect, flush_* and busy are 1 from cycle N+1.
  - br_taken/br_total are visible updated in N+1.
- With no stall, REDIRECT lasts exactly 1 cycle (N+1).
  - SQUASH covers cycles N+2 … N+1+SQUASH_CYCLES.
  - busy falls at N+2+SQUASH_CYCLES; a new resolve is possible in that cycle.
- stall_in=1 during REDIRECT stretches the pulse.
  - Outputs are held and pc_target is stable.
  - The redirect and flush pulses end one cycle after the first cycle with stall_in=0.
- Reset asserted mid-REDIRECT/SQUASH: the next edge returns to reset values and the redirect is abandoned.
- Back-to-back branches: a branch entering EX during SQUASH is wrong-path by definition and is ignored.

## Structure
- Shared package cpu_pkg holds:
  - the BEQ/BLT/BGT/BNE opcode constants
  - the flag-bit index constants
  - the FSM state enum type
- Sub-module sat_counter (parameter W; ports inc, clr; clr priority), instantiated twice for br_total and br_taken.
- The taken decision is a combinational function within this module.

## Test plan
- BEQ, flags=2'b10, target=16'h0040, no stall:
  - pc_redirect=1 for exactly 1 cycle with pc_target=16'h0040.
  - busy is high for 3 cycles.
  - br_total=1, br_taken=1.
- BNE with flags=2'b10, then BLT with flags=2'b00: no redirect; br_total=2, br_taken=0.
- BGT with flags=2'b00, stall_in=1 for 3 cycles before release:
  - Resolved once, so br_total=1.
  - Redirect pulse is 1 cycle, after release.
- Taken BEQ with stall_in=1 in REDIRECT for 2 cycles:
  - pc_redirect held for 3 cycles.
  - During SQUASH, a valid BEQ with flags=2'b10 is presented: no second redirect, counters unchanged.
- Preload the counters near all-ones, then issue taken branches: br_taken and br_total stick at 16'hFFFF. Then cnt_clr pulsed together with a resolve gives 0.
- rst_n low in the REDIRECT cycle: all outputs 0 on the next edge. SQUASH_CYCLES=0 build: busy high for 1 cycle only.
